// File: rtl/soc_onchip_mem_arbiter_pkg.sv
// Shared constants and types for the two-requester on-chip RAM arbiter.
// Read-return tags travel through a shift register matched to the RAM read latency.
package soc_mem_arb_pkg;

   localparam int ADDR_W         = 14;
   localparam int DATA_W         = 32;
   localparam int BE_W           = DATA_W / 8;
   localparam int RD_LATENCY_DEF = 1;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   typedef struct packed {
      logic     valid;
      port_id_t id;
   } rd_tag_t;

   function automatic logic is_req(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/soc_onchip_mem_arbiter_if.sv
// Avalon-MM style bus bundle used both for the requester ports and the RAM side.
// Requesters never drive chipselect; the RAM side never drives waitrequest/readdatavalid.
interface soc_onchip_mem_arbiter_if;
   import soc_mem_arb_pkg::*;

   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic              chipselect;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              waitrequest;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, chipselect, writedata,
      input  readdata, waitrequest, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output readdata, waitrequest, readdatavalid
   );

endinterface

// File: rtl/soc_rr_arb2.sv
// Two-way round-robin grant with a registered last-grant bit.
// A lone requester always wins; on a tie the port that did not win last time wins.
module soc_rr_arb2
   import soc_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_valid,
   output port_id_t   gnt_id
);

   port_id_t last_grant_r;

   // Grant decode from current requests and the previous winner.
   always_comb begin
      gnt_id    = PORT0;
      gnt_valid = 1'b0;
      gnt       = 2'b00;
      case (req)
         2'b01: begin
            gnt_id    = PORT0;
            gnt_valid = 1'b1;
         end
         2'b10: begin
            gnt_id    = PORT1;
            gnt_valid = 1'b1;
         end
         2'b11: begin
            gnt_id    = (last_grant_r == PORT0) ? PORT1 : PORT0;
            gnt_valid = 1'b1;
         end
         default: begin
            gnt_id    = PORT0;
            gnt_valid = 1'b0;
         end
      endcase
      if (gnt_valid) begin
         gnt = (gnt_id == PORT1) ? 2'b10 : 2'b01;
      end else begin
         gnt = 2'b00;
      end
   end

   // Remember the winner; reset makes port 0 win the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r <= PORT1;
      end else if (gnt_valid) begin
         last_grant_r <= gnt_id;
      end
   end

endmodule

// File: rtl/soc_onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM requesters, one transaction per cycle,
// and routes read data back to the issuing port after RD_LATENCY cycles.
module soc_onchip_mem_arbiter
   import soc_mem_arb_pkg::*;
#(
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input logic                      clk,
   input logic                      reset,
   soc_onchip_mem_arbiter_if.slave  m0,
   soc_onchip_mem_arbiter_if.slave  m1,
   soc_onchip_mem_arbiter_if.master mem
);

   logic [1:0] req_s;
   logic [1:0] gnt_s;
   logic       gnt_valid_s;
   port_id_t   gnt_id_s;
   logic       sel_wr_s;
   rd_tag_t    head_s;
   rd_tag_t [RD_LATENCY-1:0] tag_sr_r;

   // Requests are masked during reset so nothing reaches the RAM.
   always_comb begin
      req_s = 2'b00;
      if (reset) begin
         req_s = 2'b00;
      end else begin
         req_s = {is_req(m1.read, m1.write), is_req(m0.read, m0.write)};
      end
   end

   soc_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (reset),
      .req       (req_s),
      .gnt       (gnt_s),
      .gnt_valid (gnt_valid_s),
      .gnt_id    (gnt_id_s)
   );

   // Drive the granted transaction to the RAM and stall only the losing requester.
   always_comb begin
      mem.address    = m0.address;
      mem.writedata  = m0.writedata;
      sel_wr_s       = m0.write;
      mem.byteenable = m0.byteenable;
      if (gnt_id_s == PORT1) begin
         mem.address   = m1.address;
         mem.writedata = m1.writedata;
         sel_wr_s      = m1.write;
      end else begin
         mem.address   = m0.address;
         mem.writedata = m0.writedata;
         sel_wr_s      = m0.write;
      end
      if (sel_wr_s) begin
         mem.byteenable = (gnt_id_s == PORT1) ? m1.byteenable : m0.byteenable;
      end else begin
         mem.byteenable = {BE_W{1'b1}};
      end
      mem.chipselect = gnt_valid_s;
      mem.write      = gnt_valid_s & sel_wr_s;
      mem.read       = gnt_valid_s & ~sel_wr_s;
      m0.waitrequest = reset | (req_s[0] & ~gnt_s[0]);
      m1.waitrequest = reset | (req_s[1] & ~gnt_s[1]);
   end

   // Read tags ride alongside the RAM pipeline; a write with read also set yields no tag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_sr_r <= '0;
      end else begin
         tag_sr_r[0] <= rd_tag_t'{valid: gnt_valid_s & ~sel_wr_s, id: gnt_id_s};
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_sr_r[i] <= tag_sr_r[i-1];
         end
      end
   end

   // Response demux: the tag at the head of the pipe owns this cycle's RAM data.
   always_comb begin
      head_s           = tag_sr_r[RD_LATENCY-1];
      m0.readdata      = mem.readdata;
      m1.readdata      = mem.readdata;
      m0.readdatavalid = head_s.valid & (head_s.id == PORT0);
      m1.readdatavalid = head_s.valid & (head_s.id == PORT1);
   end

endmodule

// File: tb/tb_soc_onchip_mem_arbiter.sv
// Directed bench: queue-driven Avalon masters, a RAM model, and a rule-level reference
// model of the arbiter checked against the DUT every cycle.
module tb_soc_onchip_mem_arbiter;
   import soc_mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   soc_onchip_mem_arbiter_if m0_if ();
   soc_onchip_mem_arbiter_if m1_if ();
   soc_onchip_mem_arbiter_if mem_if ();

   soc_onchip_mem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .m0    (m0_if),
      .m1    (m1_if),
      .mem   (mem_if)
   );

   assign m0_if.chipselect     = 1'b0;
   assign m1_if.chipselect     = 1'b0;
   assign mem_if.waitrequest   = 1'b0;
   assign mem_if.readdatavalid = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // RAM: registered address, combinational q, byte-lane writes.
   logic [31:0] ram [0:16383];
   logic [13:0] ram_addr_r = 14'd0;
   always @(posedge clk) begin
      if (mem_if.chipselect) begin
         if (mem_if.write) begin
            for (int b = 0; b < 4; b++)
               if (mem_if.byteenable[b]) ram[mem_if.address][b*8 +: 8] <= mem_if.writedata[b*8 +: 8];
         end
         ram_addr_r <= mem_if.address;
      end
   end
   assign mem_if.readdata = ram[ram_addr_r];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [13:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } txn_t;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          due;
   } rsp_t;

   txn_t q0[$];
   txn_t q1[$];
   rsp_t exp_q[$];
   logic [31:0] gold [0:16383];
   logic [1:0]  acc = 2'b00;
   int          mdl_last = 1;
   int          cyc = 0;
   int          rdv_cnt [2] = '{0, 0};
   logic [31:0] last_rd [2];

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model and per-cycle compare.
   always @(negedge clk) begin
      logic [1:0]  r;
      int          gp;
      txn_t        t;
      logic [1:0]  exp_v;
      logic [31:0] exp_d;
      acc = 2'b00;
      if (reset) begin
         chk("rst_wait0", m0_if.waitrequest, 1);
         chk("rst_wait1", m1_if.waitrequest, 1);
         chk("rst_rdv0", m0_if.readdatavalid, 0);
         chk("rst_rdv1", m1_if.readdatavalid, 0);
         chk("rst_cs", mem_if.chipselect, 0);
         chk("rst_memwr", mem_if.write, 0);
         mdl_last = 1;
         exp_q.delete();
      end else begin
         r[0] = m0_if.read | m0_if.write;
         r[1] = m1_if.read | m1_if.write;
         gp = -1;
         if (r == 2'b11) gp = (mdl_last == 0) ? 1 : 0;
         else if (r[0]) gp = 0;
         else if (r[1]) gp = 1;
         chk("wait0", m0_if.waitrequest, r[0] && gp != 0);
         chk("wait1", m1_if.waitrequest, r[1] && gp != 1);
         chk("mem_cs", mem_if.chipselect, gp >= 0);
         if (gp >= 0) begin
            t.rd = (gp == 0) ? m0_if.read : m1_if.read;
            t.wr = (gp == 0) ? m0_if.write : m1_if.write;
            t.a  = (gp == 0) ? m0_if.address : m1_if.address;
            t.be = (gp == 0) ? m0_if.byteenable : m1_if.byteenable;
            t.d  = (gp == 0) ? m0_if.writedata : m1_if.writedata;
            chk("mem_write", mem_if.write, t.wr);
            chk("mem_addr", mem_if.address, t.a);
            if (t.wr) begin
               chk("mem_be", mem_if.byteenable, t.be);
               chk("mem_wdata", mem_if.writedata, t.d);
               for (int b = 0; b < 4; b++)
                  if (t.be[b]) gold[t.a][b*8 +: 8] = t.d[b*8 +: 8];
            end else begin
               chk("mem_be_rd", mem_if.byteenable, 4'hF);
               exp_q.push_back('{port: gp, data: gold[t.a], due: cyc + RD_LATENCY_DEF});
            end
            acc[gp] = 1'b1;
            mdl_last = gp;
         end
         exp_v = 2'b00;
         exp_d = 32'h0;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_v[exp_q[0].port] = 1'b1;
            exp_d = exp_q[0].data;
            void'(exp_q.pop_front());
         end
         chk("rdv0", m0_if.readdatavalid, exp_v[0]);
         chk("rdv1", m1_if.readdatavalid, exp_v[1]);
         if (exp_v[0]) chk("rdata0", m0_if.readdata, exp_d);
         if (exp_v[1]) chk("rdata1", m1_if.readdata, exp_d);
         if (m0_if.readdatavalid) begin rdv_cnt[0]++; last_rd[0] = m0_if.readdata; end
         if (m1_if.readdatavalid) begin rdv_cnt[1]++; last_rd[1] = m1_if.readdata; end
      end
   end

   task automatic drive_port(input int p, input txn_t t);
      if (p == 0) begin
         m0_if.read = t.rd; m0_if.write = t.wr; m0_if.address = t.a;
         m0_if.byteenable = t.be; m0_if.writedata = t.d;
      end else begin
         m1_if.read = t.rd; m1_if.write = t.wr; m1_if.address = t.a;
         m1_if.byteenable = t.be; m1_if.writedata = t.d;
      end
   endtask

   task automatic apply_heads();
      txn_t idle = '{rd: 1'b0, wr: 1'b0, a: 14'd0, be: 4'h0, d: 32'h0};
      drive_port(0, (q0.size() > 0) ? q0[0] : idle);
      drive_port(1, (q1.size() > 0) ? q1[0] : idle);
   endtask

   task automatic run_queues(input int budget, output int n);
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
         apply_heads();
         @(posedge clk); #1;
         if (acc[0]) void'(q0.pop_front());
         if (acc[1]) void'(q1.pop_front());
         n++;
      end
      if (q0.size() > 0 || q1.size() > 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: %0d requests left after %0d cycles", q0.size() + q1.size(), n);
         q0.delete(); q1.delete();
      end
      apply_heads();
      repeat (RD_LATENCY_DEF + 1) @(posedge clk);
      #1;
   endtask

   function automatic txn_t wr_t(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
      return '{rd: 1'b0, wr: 1'b1, a: a, be: be, d: d};
   endfunction

   function automatic txn_t rd_t(input logic [13:0] a);
      return '{rd: 1'b1, wr: 1'b0, a: a, be: 4'h0, d: 32'h0};
   endfunction

   initial begin
      int n;
      int c0, c1;
      for (int i = 0; i < 16384; i++) begin ram[i] = 32'h0; gold[i] = 32'h0; end
      reset = 1'b1;
      apply_heads();

      // 1: reset
      repeat (3) @(posedge clk);
      #1;
      chk("t1_wait0", m0_if.waitrequest, 1);
      chk("t1_wait1", m1_if.waitrequest, 1);
      chk("t1_cs", mem_if.chipselect, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 2: lone m0 write then read
      c0 = rdv_cnt[0];
      q0.push_back(wr_t(14'h0010, 4'hF, 32'hDEADBEEF));
      q0.push_back(rd_t(14'h0010));
      run_queues(10, n);
      chk("t2_cycles", n, 2);
      chk("t2_rdv_cnt", rdv_cnt[0] - c0, 1);
      chk("t2_rdata", last_rd[0], 32'hDEADBEEF);

      // 3: both ports fill distinct data, then read every cycle
      for (int i = 0; i < 4; i++) begin
         q0.push_back(wr_t(14'h0100 + 14'(i), 4'hF, 32'hA0000000 + 32'(i)));
         q1.push_back(wr_t(14'h0200 + 14'(i), 4'hF, 32'hB0000000 + 32'(i)));
      end
      run_queues(20, n);
      chk("t3_wr_cycles", n, 8);
      c0 = rdv_cnt[0]; c1 = rdv_cnt[1];
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rd_t(14'h0100 + 14'(i)));
         q1.push_back(rd_t(14'h0200 + 14'(i)));
      end
      run_queues(20, n);
      chk("t3_rd_cycles", n, 8);
      chk("t3_rdv_cnt0", rdv_cnt[0] - c0, 4);
      chk("t3_rdv_cnt1", rdv_cnt[1] - c1, 4);
      chk("t3_last0", last_rd[0], 32'hA0000003);
      chk("t3_last1", last_rd[1], 32'hB0000003);

      // 4: partial byte write on m1 at top address
      q1.push_back(wr_t(14'h3FFF, 4'hF, 32'hFFFFFFFF));
      q1.push_back(wr_t(14'h3FFF, 4'h3, 32'h1234ABCD));
      q1.push_back(rd_t(14'h3FFF));
      run_queues(10, n);
      chk("t4_rdata", last_rd[1], 32'hFFFFABCD);

      // 5: read accepted, reset next cycle drops it; first tie after reset goes to m0
      c0 = rdv_cnt[0];
      q0.push_back(rd_t(14'h0010));
      apply_heads();
      @(posedge clk); #1;
      chk("t5_acc", acc[0], 1);
      reset = 1'b1;
      q0.delete();
      apply_heads();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t5_no_rdv", rdv_cnt[0] - c0, 0);
      q0.push_back(rd_t(14'h0010));
      q1.push_back(rd_t(14'h3FFF));
      apply_heads();
      #2;
      chk("t5_tie_wait0", m0_if.waitrequest, 0);
      chk("t5_tie_wait1", m1_if.waitrequest, 1);
      run_queues(10, n);
      chk("t5_cycles", n, 2);

      // 6: read+write together is a write with no response
      c0 = rdv_cnt[0];
      q0.push_back('{rd: 1'b1, wr: 1'b1, a: 14'h0020, be: 4'hF, d: 32'h55AA55AA});
      run_queues(10, n);
      chk("t6_no_rdv", rdv_cnt[0] - c0, 0);
      q0.push_back(rd_t(14'h0020));
      run_queues(10, n);
      chk("t6_rdv_cnt", rdv_cnt[0] - c0, 1);
      chk("t6_rdata", last_rd[0], 32'h55AA55AA);
      chk("t6_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
